data_mem_ctrl: RTL and testbench

- Parametrised data memory for the single-cycle/multi-cycle CPU labs.
- Extends the fixed 64-word word-only RAM to a configurable depth.
- Adds byte and halfword stores with lane enables, sign/zero-extended sub-word loads, misalignment detection and programmable access latency.
- Sits between the CPU MEM stage and an internal word array; the CPU talks to it through a req/busy/done handshake.

---
 rtl/data_mem_ctrl_if.sv | 32 +++
 rtl/data_mem_ctrl.sv | 171 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl_if
//  Description : CPU <-> data memory handshake bundle (req/busy/done).
//  Revision    : 1.0  initial release
// ============================================================================
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;

  // CPU side drives the request, memory side drives the response
  modport master (
    output req, we, size, sext, addr, wdata,
    input  busy, done, err, rdata
  );

  modport slave (
    input  req, we, size, sext, addr, wdata,
    output busy, done, err, rdata
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : Parametrised byte/half/word data memory with programmable
//                access latency, sub-word sign/zero extension and
//                misalignment rejection, behind a req/busy/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 1
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  data_mem_ctrl_if.slave    bus
);

  localparam int         DEPTH  = 1 << (ADDR_W - 2);
  localparam logic [3:0] c_WAIT = 4'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sext;
  logic              r_rej;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem [DEPTH];

  logic              w_misaligned;
  logic              w_access;
  logic [ADDR_W-3:0] w_idx;
  logic [31:0]       w_word;
  logic [7:0]        w_lane8;
  logic [15:0]       w_lane16;
  logic [31:0]       w_load;
  logic [3:0]        w_be;
  logic [31:0]       w_wword;

  assign w_idx    = r_addr[ADDR_W-1:2];
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

  // Alignment check on the incoming request (reserved size always rejected)
  always_comb begin
    w_misaligned = 1'b0;
    case (bus.size)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = bus.addr[0];
      2'b10:   w_misaligned = |bus.addr[1:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  // Load path: pick the addressed lane(s), right-align and extend
  always_comb begin
    w_word   = r_mem[w_idx];
    w_lane8  = w_word[{r_addr[1:0], 3'b000} +: 8];
    w_lane16 = r_addr[1] ? w_word[31:16] : w_word[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_sext & w_lane8[7]}}, w_lane8};
      2'b01:   w_load = {{16{r_sext & w_lane16[15]}}, w_lane16};
      default: w_load = w_word;
    endcase
  end

  // Store path: replicate right-aligned data across lanes, enable only the addressed ones
  always_comb begin
    w_be    = 4'b1111;
    w_wword = r_wdata;
    case (r_size)
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wword = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wword = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wword = r_wdata;
      end
    endcase
  end

  // Word array: written only on the access edge of an accepted store, never cleared.
  // Reset forces the FSM out of WAIT asynchronously, so an aborted store cannot land here.
  always_ff @(posedge clk) begin
    if (w_access && r_we && !r_rej) begin
      for (int n = 0; n < 4; n++) begin
        if (w_be[n]) r_mem[w_idx][8*n +: 8] <= w_wword[8*n +: 8];
      end
    end
  end

  // Control FSM with registered handshake outputs.
  // A rejected request passes through WAIT with a zero count so done/err
  // arrive one edge after the accept, without touching the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_sext  <= 1'b0;
      r_rej   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_size  <= bus.size;
            r_sext  <= bus.sext;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_rej   <= w_misaligned;
            r_cnt   <= w_misaligned ? 4'd0 : c_WAIT;
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (!r_we && !r_rej) r_rdata <= w_load;
            r_done  <= 1'b1;
            r_err   <= r_rej;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_ctrl
//  Description : Self-checking bench for data_mem_ctrl, WAIT=1 and WAIT=3
//                instances against a byte-addressed reference memory.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_ctrl;

  logic clk;
  logic rst1;
  logic rst3;
  int   total = 0;
  int   bad   = 0;

  // reference state: byte-addressed memory and last load result per instance
  logic [7:0]  mb     [2][256];
  logic [31:0] last_r [2];

  data_mem_ctrl_if #(.ADDR_W(8)) if1 ();
  data_mem_ctrl_if #(.ADDR_W(8)) if3 ();

  data_mem_ctrl #(.ADDR_W(8), .WAIT(1)) dut1 (.clk(clk), .rst_n(rst1), .bus(if1));
  data_mem_ctrl #(.ADDR_W(8), .WAIT(3)) dut3 (.clk(clk), .rst_n(rst3), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int d, input logic rq, input logic we, input logic [1:0] sz,
                     input logic sx, input logic [7:0] a, input logic [31:0] wd);
    if (d == 1) begin
      if1.req = rq; if1.we = we; if1.size = sz; if1.sext = sx; if1.addr = a; if1.wdata = wd;
    end else begin
      if3.req = rq; if3.we = we; if3.size = sz; if3.sext = sx; if3.addr = a; if3.wdata = wd;
    end
  endtask

  task automatic set_req(input int d, input logic rq);
    if (d == 1) if1.req = rq; else if3.req = rq;
  endtask

  task automatic rd(input int d, output logic b, output logic dn, output logic e, output logic [31:0] r);
    if (d == 1) begin b = if1.busy; dn = if1.done; e = if1.err; r = if1.rdata; end
    else        begin b = if3.busy; dn = if3.done; e = if3.err; r = if3.rdata; end
  endtask

  function automatic bit misal(input logic [1:0] sz, input logic [7:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  task automatic model_store(input int dd, input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) mb[dd][(int'(a) + i) & 255] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] model_load(input int dd, input logic [1:0] sz, input logic sx, input logic [7:0] a);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < nbytes(sz); i++) v[8*i +: 8] = mb[dd][(int'(a) + i) & 255];
    if (sx && sz == 2'b00) v = {{24{v[7]}}, v[7:0]};
    if (sx && sz == 2'b01) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // One complete access, entered and left one ns after a rising edge with the DUT idle.
  task automatic access(input int d, input logic we, input logic [1:0] sz, input logic sx,
                        input logic [7:0] a, input logic [31:0] wd, input bit hold,
                        output logic [31:0] obs);
    int          dd;
    int          lat;
    int          exp_lat;
    bit          rej;
    logic [31:0] exp_r;
    logic        b, dn, e;
    logic [31:0] r;
    dd      = (d == 1) ? 0 : 1;
    rej     = misal(sz, a);
    exp_lat = rej ? 1 : d + 1;
    if (rej || we) exp_r = last_r[dd];
    else           exp_r = model_load(dd, sz, sx, a);
    if (!rej && we) model_store(dd, sz, a, wd);
    drv(d, 1'b1, we, sz, sx, a, wd);
    @(posedge clk); #1;
    if (!hold) set_req(d, 1'b0);
    rd(d, b, dn, e, r);
    check("busy_after_accept", {31'd0, b}, 32'd1);
    lat = 0;
    while (!dn && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      rd(d, b, dn, e, r);
    end
    check("done_latency", lat, exp_lat);
    check("busy_at_done", {31'd0, b}, 32'd1);
    check("err_at_done", {31'd0, e}, {31'd0, rej});
    check("rdata_at_done", r, exp_r);
    obs = r;
    last_r[dd] = exp_r;
    @(posedge clk); #1;
    rd(d, b, dn, e, r);
    check("done_one_cycle", {31'd0, dn}, 32'd0);
    check("idle_after_resp", {31'd0, b}, 32'd0);
  endtask

  task automatic rand_access(input int d);
    logic [1:0]  sz;
    logic [7:0]  a;
    logic [31:0] o;
    sz = 2'($urandom_range(0, 3));
    a  = 8'($urandom);
    if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~8'((1 << sz) - 1);
    access(d, 1'($urandom), sz, 1'($urandom), a, $urandom, 1'b0, o);
  endtask

  initial begin
    logic [31:0] o;
    logic [31:0] old30;
    logic        b, dn, e;
    logic [31:0] r;
    int          lat;
    last_r[0] = 32'd0;
    last_r[1] = 32'd0;
    rst1 = 1'b1;
    rst3 = 1'b1;
    drv(1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 32'd0);
    drv(3, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 32'd0);
    #2;
    rst1 = 1'b0;
    rst3 = 1'b0;
    #1;
    rd(1, b, dn, e, r);
    check("rst_busy", {31'd0, b}, 32'd0);
    check("rst_done", {31'd0, dn}, 32'd0);
    check("rst_err", {31'd0, e}, 32'd0);
    check("rst_rdata", r, 32'd0);
    rd(3, b, dn, e, r);
    check("rst3_busy", {31'd0, b}, 32'd0);
    check("rst3_rdata", r, 32'd0);
    #20;
    rst1 = 1'b1;
    rst3 = 1'b1;
    @(posedge clk); #1;

    // give every word a known value in both instances
    for (int i = 0; i < 64; i++) begin
      access(1, 1'b1, 2'b10, 1'b0, 8'(i * 4), $urandom, 1'b0, o);
      access(3, 1'b1, 2'b10, 1'b0, 8'(i * 4), $urandom, 1'b0, o);
    end

    // word store/load round trip
    access(1, 1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, o);
    access(1, 1'b0, 2'b10, 1'b0, 8'h10, 32'd0, 1'b0, o);
    check("word_roundtrip", o, 32'hDEADBEEF);

    // byte store into upper lane, sign and zero extended reloads
    access(1, 1'b1, 2'b10, 1'b0, 8'h10, 32'h11223344, 1'b0, o);
    access(1, 1'b1, 2'b00, 1'b0, 8'h13, 32'h00000080, 1'b0, o);
    access(1, 1'b0, 2'b10, 1'b0, 8'h10, 32'd0, 1'b0, o);
    check("byte_merge", o, 32'h80223344);
    access(1, 1'b0, 2'b00, 1'b1, 8'h13, 32'd0, 1'b0, o);
    check("byte_sext", o, 32'hFFFFFF80);
    access(1, 1'b0, 2'b00, 1'b0, 8'h13, 32'd0, 1'b0, o);
    check("byte_zext", o, 32'h00000080);

    // half store into upper half
    access(1, 1'b1, 2'b10, 1'b0, 8'h20, 32'h00000000, 1'b0, o);
    access(1, 1'b1, 2'b01, 1'b0, 8'h22, 32'h0000A5A5, 1'b0, o);
    access(1, 1'b0, 2'b10, 1'b0, 8'h20, 32'd0, 1'b0, o);
    check("half_merge", o, 32'hA5A50000);
    access(1, 1'b0, 2'b01, 1'b1, 8'h22, 32'd0, 1'b0, o);
    check("half_sext", o, 32'hFFFFA5A5);
    access(1, 1'b0, 2'b01, 1'b1, 8'h20, 32'd0, 1'b0, o);
    check("half_low", o, 32'h00000000);

    // rejected accesses: misaligned word and reserved size
    access(1, 1'b1, 2'b10, 1'b0, 8'h05, 32'h12345678, 1'b0, o);
    check("rej_word_rdata_kept", o, 32'h00000000);
    access(1, 1'b1, 2'b11, 1'b0, 8'h04, 32'h12345678, 1'b0, o);
    access(1, 1'b0, 2'b11, 1'b0, 8'h04, 32'd0, 1'b0, o);
    access(1, 1'b0, 2'b01, 1'b0, 8'h21, 32'd0, 1'b0, o);
    access(1, 1'b0, 2'b10, 1'b0, 8'h04, 32'd0, 1'b0, o);

    // randomized mix on both latencies
    for (int i = 0; i < 150; i++) rand_access(1);
    for (int i = 0; i < 40; i++)  rand_access(3);

    // request held high through a whole WAIT=3 access
    access(3, 1'b0, 2'b10, 1'b0, 8'h40, 32'd0, 1'b1, o);
    @(posedge clk); #1;
    rd(3, b, dn, e, r);
    check("hold_reaccept_after_idle", {31'd0, b}, 32'd1);
    set_req(3, 1'b0);
    lat = 0;
    dn  = 1'b0;
    while (!dn && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      rd(3, b, dn, e, r);
    end
    check("hold_second_latency", lat, 4);
    check("hold_second_rdata", r, model_load(1, 2'b10, 1'b0, 8'h40));
    @(posedge clk); #1;
    rd(3, b, dn, e, r);
    check("hold_idle_after", {31'd0, b}, 32'd0);

    // reset during the wait phase of a store aborts it
    old30 = model_load(0, 2'b10, 1'b0, 8'h30);
    drv(1, 1'b1, 1'b1, 2'b10, 1'b0, 8'h30, ~old30);
    @(posedge clk); #1;
    set_req(1, 1'b0);
    rst1 = 1'b0;
    #1;
    rd(1, b, dn, e, r);
    check("abort_busy", {31'd0, b}, 32'd0);
    check("abort_done", {31'd0, dn}, 32'd0);
    check("abort_err", {31'd0, e}, 32'd0);
    check("abort_rdata", r, 32'd0);
    last_r[0] = 32'd0;
    #10;
    rst1 = 1'b1;
    @(posedge clk); #1;
    access(1, 1'b0, 2'b10, 1'b0, 8'h30, 32'd0, 1'b0, o);
    check("abort_no_write", o, old30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
